// File: rtl/i2c_byte_arbiter.sv
// i2c_byte_arbiter
// Lets NUM_REQ requesters share one i2c_master_byte command interface.
// Ownership covers a whole I2C transaction, from the first command up to the
// STOP, and is handed out round-robin. Each byte command is latched and held
// until the byte master acknowledges it. A watchdog aborts any command that
// stays outstanding for TIMEOUT_CYC cycles.
//
// Ports
//   clk_i, arst_i                 clock, async active-high reset
//   req_i / gnt_o                 per-requester transaction request / one-hot grant
//   start_i..ack_in_i, din_i      per-requester command bits and write byte
//   cmd_ack_o, timeout_o          one-cycle done / abort pulses to the owner
//   dout_o                        last read byte, valid with cmd_ack_o
//   m_*_o, m_din_o                command to the byte master
//   m_cmd_ack_i, m_dout_i         byte master done and read data
//   bus_rst_o                     one-cycle byte master reset on watchdog abort
//
// state   | meaning
// IDLE    | no owner; round-robin pick among active requests
// OWNED   | owner holds the bus and may present a command
// ISSUE   | latched command is driven to the byte master, waiting for its ack
// RELEASE | one-cycle grant gap between transactions
module i2c_byte_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic [NUM_REQ-1:0]            start_i,
    input  logic [NUM_REQ-1:0]            stop_i,
    input  logic [NUM_REQ-1:0]            read_i,
    input  logic [NUM_REQ-1:0]            write_i,
    input  logic [NUM_REQ-1:0]            ack_in_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_i,
    output logic [NUM_REQ-1:0]            cmd_ack_o,
    output logic [DATA_WIDTH-1:0]         dout_o,
    output logic [NUM_REQ-1:0]            timeout_o,
    output logic                          m_start_o,
    output logic                          m_stop_o,
    output logic                          m_read_o,
    output logic                          m_write_o,
    output logic                          m_ack_in_o,
    output logic [DATA_WIDTH-1:0]         m_din_o,
    input  logic                          m_cmd_ack_i,
    input  logic [DATA_WIDTH-1:0]         m_dout_i,
    output logic                          bus_rst_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, OWNED, ISSUE, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, last_owner, sel;
    logic          sel_valid;
    logic [CW-1:0] wd_cnt;
    logic          owner_cmd;
    logic          grant, capture, done, expire;

    // Round-robin pick: the first active request after last_owner, wrapping.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!sel_valid && req_i[(int'(last_owner) + i) % NUM_REQ]) begin
                sel       = IW'((int'(last_owner) + i) % NUM_REQ);
                sel_valid = 1'b1;
            end
        end
    end

    assign owner_cmd = start_i[owner] | stop_i[owner] | read_i[owner] |
                       write_i[owner] | ack_in_i[owner];

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    grant     = 1'b1;
                    state_nxt = OWNED;
                end
            end
            OWNED: begin
                if (!req_i[owner]) begin
                    state_nxt = RELEASE;
                // While the ack pulse is out the owner is still dropping the
                // previous command's bits; capturing now would repeat it.
                end else if (owner_cmd && !cmd_ack_o[owner]) begin
                    capture   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (m_cmd_ack_i) begin
                    done      = 1'b1;
                    state_nxt = (m_stop_o || !req_i[owner]) ? RELEASE : OWNED;
                end else if ((TIMEOUT_CYC > 0) && (wd_cnt == CW'(TIMEOUT_CYC - 1))) begin
                    expire    = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant decodes straight from state so an async reset drops it at once.
    always_comb begin
        gnt_o = '0;
        if (state == OWNED || state == ISSUE) gnt_o[owner] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            wd_cnt     <= '0;
            m_start_o  <= 1'b0;
            m_stop_o   <= 1'b0;
            m_read_o   <= 1'b0;
            m_write_o  <= 1'b0;
            m_ack_in_o <= 1'b0;
            m_din_o    <= '0;
            cmd_ack_o  <= '0;
            timeout_o  <= '0;
            bus_rst_o  <= 1'b0;
            dout_o     <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ack_o <= '0;
            timeout_o <= '0;
            bus_rst_o <= 1'b0;

            if (grant) begin
                owner      <= sel;
                last_owner <= sel;
            end

            if (capture) begin
                m_start_o  <= start_i[owner];
                m_stop_o   <= stop_i[owner];
                m_read_o   <= read_i[owner];
                m_write_o  <= write_i[owner];
                m_ack_in_o <= ack_in_i[owner];
                m_din_o    <= din_i[owner*DATA_WIDTH +: DATA_WIDTH];
                wd_cnt     <= '0;
            end else if (state == ISSUE && !done && !expire && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (done || expire) begin
                m_start_o  <= 1'b0;
                m_stop_o   <= 1'b0;
                m_read_o   <= 1'b0;
                m_write_o  <= 1'b0;
                m_ack_in_o <= 1'b0;
                m_din_o    <= '0;
            end

            // An owner that has already walked away gets no pulses.
            if (done) begin
                dout_o           <= m_dout_i;
                cmd_ack_o[owner] <= req_i[owner];
            end

            if (expire) begin
                timeout_o[owner] <= req_i[owner];
                bus_rst_o        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_arbiter.sv
module tb_i2c_byte_arbiter;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic [1:0]  req_i, gnt_o;
    logic [1:0]  start_i, stop_i, read_i, write_i, ack_in_i;
    logic [15:0] din_i;
    logic [1:0]  cmd_ack_o, timeout_o;
    logic [7:0]  dout_o, m_din_o, m_dout_i;
    logic        m_start_o, m_stop_o, m_read_o, m_write_o, m_ack_in_o;
    logic        m_cmd_ack_i, bus_rst_o;

    int checks   = 0;
    int failures = 0;

    wire [4:0] m_bus = {m_start_o, m_stop_o, m_read_o, m_write_o, m_ack_in_o};

    i2c_byte_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .req_i(req_i), .gnt_o(gnt_o),
        .start_i(start_i), .stop_i(stop_i), .read_i(read_i), .write_i(write_i),
        .ack_in_i(ack_in_i), .din_i(din_i), .cmd_ack_o(cmd_ack_o), .dout_o(dout_o),
        .timeout_o(timeout_o), .m_start_o(m_start_o), .m_stop_o(m_stop_o),
        .m_read_o(m_read_o), .m_write_o(m_write_o), .m_ack_in_o(m_ack_in_o),
        .m_din_o(m_din_o), .m_cmd_ack_i(m_cmd_ack_i), .m_dout_i(m_dout_i),
        .bus_rst_o(bus_rst_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle ack from the byte master model.
    task automatic master_ack(input logic [7:0] rdata);
        m_cmd_ack_i = 1'b1;
        m_dout_i    = rdata;
        tick();
        m_cmd_ack_i = 1'b0;
        m_dout_i    = 8'h00;
    endtask

    task automatic clear_cmds();
        start_i = 2'b00; stop_i = 2'b00; read_i = 2'b00;
        write_i = 2'b00; ack_in_i = 2'b00;
    endtask

    initial begin
        arst_i = 1'b1; req_i = 2'b00; din_i = 16'h0000;
        m_cmd_ack_i = 1'b0; m_dout_i = 8'h00;
        clear_cmds();
        tick();
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_mbus", m_bus, 5'b00000);
        chk("rst_mdin", m_din_o, 8'h00);
        chk("rst_ack", cmd_ack_o, 2'b00);
        chk("rst_tmo", {timeout_o, bus_rst_o}, 3'b000);
        arst_i = 1'b0;
        tick();
        chk("idle_gnt", gnt_o, 2'b00);

        // Single requester, three-byte write transaction.
        req_i = 2'b01;
        tick();
        chk("t1_gnt", gnt_o, 2'b01);
        start_i = 2'b01; write_i = 2'b01; din_i = 16'h00D0;
        tick();
        chk("t1_b0_din", m_din_o, 8'hD0);
        chk("t1_b0_bus", m_bus, 5'b10010);
        tick();
        chk("t1_b0_hold", m_din_o, 8'hD0);
        master_ack(8'h00);
        chk("t1_b0_ack", cmd_ack_o, 2'b01);
        chk("t1_b0_clr", m_bus, 5'b00000);
        clear_cmds();
        tick();
        chk("t1_b0_pulse", cmd_ack_o, 2'b00);
        write_i = 2'b01; din_i = 16'h0001;
        tick();
        chk("t1_b1_din", m_din_o, 8'h01);
        chk("t1_b1_bus", m_bus, 5'b00010);
        master_ack(8'h00);
        chk("t1_b1_ack", cmd_ack_o, 2'b01);
        clear_cmds();
        tick();
        stop_i = 2'b01; write_i = 2'b01; din_i = 16'h0023;
        tick();
        chk("t1_b2_din", m_din_o, 8'h23);
        chk("t1_b2_bus", m_bus, 5'b01010);
        chk("t1_b2_gnt", gnt_o, 2'b01);
        master_ack(8'h00);
        chk("t1_b2_ack", cmd_ack_o, 2'b01);
        chk("t1_rel_gnt", gnt_o, 2'b00);
        clear_cmds(); req_i = 2'b00;
        tick();
        chk("t1_idle_gnt", gnt_o, 2'b00);
        tick();

        // Round-robin fairness from reset.
        arst_i = 1'b1;
        tick();
        arst_i = 1'b0;
        req_i = 2'b11;
        tick();
        chk("t2_first", gnt_o, 2'b01);
        stop_i = 2'b01; write_i = 2'b01; din_i = 16'h2211;
        tick();
        chk("t2_r0_din", m_din_o, 8'h11);
        master_ack(8'h00);
        chk("t2_r0_ack", cmd_ack_o, 2'b01);
        chk("t2_gap", gnt_o, 2'b00);
        clear_cmds(); req_i = 2'b10;
        tick();
        chk("t2_idle", gnt_o, 2'b00);
        req_i = 2'b11;
        tick();
        chk("t2_second", gnt_o, 2'b10);
        stop_i = 2'b10; write_i = 2'b10;
        tick();
        chk("t2_r1_din", m_din_o, 8'h22);
        master_ack(8'h00);
        chk("t2_r1_ack", cmd_ack_o, 2'b10);
        chk("t2_gap2", gnt_o, 2'b00);
        clear_cmds(); req_i = 2'b01;
        tick();
        tick();
        chk("t2_third", gnt_o, 2'b01);
        req_i = 2'b00;
        tick();
        tick();

        // Non-owner isolation.
        req_i = 2'b01;
        tick();
        chk("t3_gnt", gnt_o, 2'b01);
        write_i = 2'b11; din_i = 16'h553C;
        tick();
        chk("t3_din", m_din_o, 8'h3C);
        master_ack(8'h00);
        chk("t3_ack", cmd_ack_o, 2'b01);
        write_i = 2'b10;
        tick();
        chk("t3_nocap", m_bus, 5'b00000);
        chk("t3_noack", cmd_ack_o, 2'b00);
        tick();
        chk("t3_nocap2", m_din_o, 8'h00);
        req_i = 2'b00;
        tick();
        chk("t3_rel", {gnt_o, cmd_ack_o}, 4'b0000);
        tick();
        chk("t3_nogrant", {gnt_o, cmd_ack_o}, 4'b0000);
        write_i = 2'b00;

        // Read with bits held through the ack cycle.
        req_i = 2'b01;
        tick();
        read_i = 2'b01; ack_in_i = 2'b01;
        tick();
        chk("t4_bus", m_bus, 5'b00101);
        master_ack(8'hA7);
        chk("t4_dout", dout_o, 8'hA7);
        chk("t4_ack", cmd_ack_o, 2'b01);
        tick();
        chk("t4_nodouble", m_bus, 5'b00000);
        chk("t4_gnt", gnt_o, 2'b01);
        chk("t4_dout_hold", dout_o, 8'hA7);
        clear_cmds(); req_i = 2'b00;
        tick();
        tick();

        // Watchdog: requester 1 owns, master never acks.
        req_i = 2'b10;
        tick();
        chk("t5_gnt", gnt_o, 2'b10);
        write_i = 2'b10; din_i = 16'h9900;
        tick();
        chk("t5_bus", m_bus, 5'b00010);
        req_i = 2'b11;
        for (int i = 0; i < 15; i++) tick();
        chk("t5_early", {timeout_o, bus_rst_o}, 3'b000);
        chk("t5_held", m_din_o, 8'h99);
        tick();
        chk("t5_tmo", timeout_o, 2'b10);
        chk("t5_busrst", bus_rst_o, 1'b1);
        chk("t5_mclr", m_bus, 5'b00000);
        chk("t5_rel", gnt_o, 2'b00);
        clear_cmds(); req_i = 2'b01;
        tick();
        chk("t5_pulse", {timeout_o, bus_rst_o}, 3'b000);
        tick();
        chk("t5_next", gnt_o, 2'b01);

        // Async reset in the middle of ISSUE.
        write_i = 2'b01; din_i = 16'h0042; req_i = 2'b11;
        tick();
        chk("t6_bus", m_bus, 5'b00010);
        #2;
        arst_i = 1'b1;
        #1;
        chk("t6_gnt", gnt_o, 2'b00);
        chk("t6_bus0", m_bus, 5'b00000);
        chk("t6_din0", m_din_o, 8'h00);
        clear_cmds();
        tick();
        arst_i = 1'b0;
        tick();
        chk("t6_both", gnt_o, 2'b01);
        arst_i = 1'b1; req_i = 2'b10;
        tick();
        arst_i = 1'b0;
        tick();
        chk("t6_only1", gnt_o, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
